lift_ter_mac: RTL
=================

LIFT_TER_MAC -- requirements
Module: lift_ter_mac

Interface
REQ-001 SHALL have parameter N_PAIRS, default 351: coefficient pairs per dot product (701 coefficients, last pair's second slot zero-padded).
REQ-002 SHALL have parameter CW, default 9: counter width, with 2^CW > N_PAIRS.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a dot product; accepted only in IDLE.
REQ-006 SHALL have port phi_pair  input  4  two inverse-Phi1 ternary coefficients: [3:2] current, [1:0] previous.
REQ-007 SHALL have port coef_pair  input  4  two input-polynomial ternary coefficients, aligned slot-for-slot with phi_pair.
REQ-008 SHALL have port in_valid  input  1  phi_pair and coef_pair are valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-010 SHALL have port acc  output  2  ternary result.
REQ-011 SHALL have port out_valid  output  1  acc is final.
REQ-012 SHALL have port out_ready  input  1  consumer takes acc.
REQ-013 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL use ternary encoding 2'b00=0, 2'b01=+1, 2'b10=-1 (2 mod 3); 2'b11 is invalid and treated as 0 in all arithmetic.
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; on start go to RUN, clear accumulator to 00 and clear counter to 0.
REQ-017 RUN: in_ready=1; each cycle with in_valid=1, acc_next = acc + phi[3:2]*coef[3:2] + phi[1:0]*coef[1:0] mod 3, and counter increments.
REQ-018 RUN: a cycle with in_valid=0 SHALL leave accumulator and counter unchanged (stall, no bubble penalty).
REQ-019 On the accepting cycle where counter == N_PAIRS-1, SHALL register the final sum and go to DONE; out_valid rises on the next edge (1-cycle latency after the last pair).
REQ-020 DONE: out_valid=1, in_ready=0, acc stable; on out_ready=1 go to IDLE, with out_valid low on the following cycle.
REQ-021 start while in RUN or DONE SHALL be ignored.
REQ-022 A start pulse in the same cycle as the DONE-to-IDLE transition SHALL be ignored; a new start is required in IDLE.
REQ-023 The counter SHALL NOT wrap; it saturates in DONE until cleared by start.
REQ-024 All arithmetic SHALL be mod 3; no intermediate value leaves the 2-bit encoding at the register boundary.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE, acc=00, counter=0, out_valid=0, in_ready=0, busy=0.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL discard the partial result; no out_valid pulse follows.
REQ-027 Reset deassertion SHALL take effect at the next rising edge; the first start is accepted on that edge or later.

Configuration
REQ-028 Macro LIFT_TER_INVCHK_EN defined: SHALL add output err (1 bit), a sticky flag set when an accepted pair contains code 2'b11 in any slot, and cleared by start or reset.
REQ-029 Macro LIFT_TER_INVCHK_EN undefined: the err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 N_PAIRS=4, pairs phi=4'b0101, coef=4'b0101 with no stalls -> acc=2'b10 (8 mod 3), out_valid 1 cycle after the 4th pair.
REQ-031 Same stimulus with in_valid low on alternate cycles -> same acc=2'b10; the number of accepted pairs is exactly 4.
REQ-032 phi=4'b1001, coef=4'b1010 (sum (-1)(-1) + (1)(-1) = 0) repeated 4 times -> acc=2'b00.
REQ-033 Reset pulsed after the 2nd pair -> out_valid stays 0; a fresh start followed by 4 pairs -> correct result.
REQ-034 out_ready held low 10 cycles in DONE -> acc and out_valid stable; start pulses during DONE are ignored.
REQ-035 With LIFT_TER_INVCHK_EN defined, a pair containing 2'b11 -> err=1 until the next start, and that slot contributes 0 to acc.

Source files
------------

// File: rtl/lift_ter_mac_if.sv
// lift_ter_mac_if: handshake and data bundle for the ternary lifting MAC.
// The master side (producer/consumer of the block) drives start, the
// coefficient pairs and out_ready; the slave side (lift_ter_mac) drives
// in_ready, acc, out_valid and busy.
// Optional feature macro: LIFT_TER_INVCHK_EN adds the sticky err flag.
interface lift_ter_mac_if;
  logic       start;
  logic [3:0] phi_pair;
  logic [3:0] coef_pair;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] acc;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef LIFT_TER_INVCHK_EN
  logic       err;

  modport master (
    output start, phi_pair, coef_pair, in_valid, out_ready,
    input  in_ready, acc, out_valid, busy, err
  );

  modport slave (
    input  start, phi_pair, coef_pair, in_valid, out_ready,
    output in_ready, acc, out_valid, busy, err
  );
`else
  modport master (
    output start, phi_pair, coef_pair, in_valid, out_ready,
    input  in_ready, acc, out_valid, busy
  );

  modport slave (
    input  start, phi_pair, coef_pair, in_valid, out_ready,
    output in_ready, acc, out_valid, busy
  );
`endif
endinterface

// File: rtl/lift_ter_mac.sv
// lift_ter_mac: ternary (mod 3) dot-product engine used for the inverse-Phi1
// lifting step. Two coefficient pairs are multiplied and accumulated per
// accepted beat; after N_PAIRS beats the mod-3 sum is held until consumed.
// Ternary codes: 00=0, 01=+1, 10=-1, 11=invalid (treated as 0).
// Optional feature macro: LIFT_TER_INVCHK_EN adds a sticky err output that
// flags any accepted slot carrying the invalid code 11.
module lift_ter_mac #(
  parameter int N_PAIRS = 351,
  parameter int CW      = 9
) (
  input  logic           clk,
  input  logic           rst,
  lift_ter_mac_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N_PAIRS - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [1:0]    r_acc;
  logic [1:0]    w_nextAcc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nextCnt;
  logic [1:0]    w_prodHi;
  logic [1:0]    w_prodLo;
  logic [1:0]    w_sum;

  // Map a ternary code to its residue 0/1/2, folding the invalid code to 0.
  function automatic logic [1:0] ternVal(input logic [1:0] code);
    return (code == 2'b11) ? 2'b00 : code;
  endfunction

  // Mod-3 product of two ternary codes: zero if either is zero, +1 if the
  // signs agree, -1 otherwise.
  function automatic logic [1:0] ternMul(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] va;
    logic [1:0] vb;
    va = ternVal(a);
    vb = ternVal(b);
    if ((va == 2'b00) || (vb == 2'b00)) begin
      return 2'b00;
    end else if (va == vb) begin
      return 2'b01;
    end else begin
      return 2'b10;
    end
  endfunction

  // Mod-3 sum of two residues, kept inside the 2-bit encoding.
  function automatic logic [1:0] ternAdd(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, ternVal(a)} + {1'b0, ternVal(b)};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

  // Per-beat products and the running sum they produce.
  always_comb begin
    w_prodHi = ternMul(bus.phi_pair[3:2], bus.coef_pair[3:2]);
    w_prodLo = ternMul(bus.phi_pair[1:0], bus.coef_pair[1:0]);
    w_sum    = ternAdd(ternAdd(r_acc, w_prodHi), w_prodLo);
  end

`ifdef LIFT_TER_INVCHK_EN
  logic r_err;
  logic w_nextErr;
  logic w_hasInvalid;

  // Any slot of an accepted beat carrying code 11 raises the sticky flag.
  always_comb begin
    w_hasInvalid = (bus.phi_pair[3:2]  == 2'b11) || (bus.phi_pair[1:0]  == 2'b11) ||
                   (bus.coef_pair[3:2] == 2'b11) || (bus.coef_pair[1:0] == 2'b11);
  end
`endif

  // Next-state and datapath updates; hold everything unless a transition fires.
  always_comb begin
    w_nextState = r_state;
    w_nextAcc   = r_acc;
    w_nextCnt   = r_cnt;
`ifdef LIFT_TER_INVCHK_EN
    w_nextErr   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nextState = S_RUN;
          w_nextAcc   = 2'b00;
          w_nextCnt   = '0;
`ifdef LIFT_TER_INVCHK_EN
          w_nextErr   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (bus.in_valid) begin
          w_nextAcc = w_sum;
          w_nextCnt = r_cnt + CW'(1);
`ifdef LIFT_TER_INVCHK_EN
          w_nextErr = r_err | w_hasInvalid;
`endif
          if (r_cnt == LAST_IDX) begin
            w_nextState = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State, accumulator and beat counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_acc   <= w_nextAcc;
      r_cnt   <= w_nextCnt;
    end
  end

`ifdef LIFT_TER_INVCHK_EN
  // Sticky invalid-code flag, cleared by an accepted start or by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_nextErr;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.in_ready  = (r_state == S_RUN);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.acc       = r_acc;

endmodule
